// File: rtl/debounce_switch_array.sv
// debounce_switch_array: N-channel switch/button debouncer.
// Each channel synchronises its raw input, requires DEBOUNCE_LIMIT consecutive
// samples at a new level before accepting it, and emits registered rise, fall
// and one-shot long-press pulses. Channels share no state.

module debounce_switch_array #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned LONG_LIMIT     = 25000000,
    parameter logic        RESET_STATE    = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Long
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int unsigned LONG_W = $clog2(LONG_LIMIT + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_LIMIT - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_LIMIT);

    for (genvar n = 0; n < int'(NUM_CH); n++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_out;

        logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        logic [LONG_W-1:0]      long_cnt_q, long_cnt_d;
        logic                   long_q, long_d;

        // Metastability synchroniser: shift the raw pin through SYNC_STAGES flops.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                sync_q <= {SYNC_STAGES{RESET_STATE}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], i_Switch[n]};
            end
        end

        assign sync_out = sync_q[SYNC_STAGES-1];

        // Stability counter: accept the synchronised level once it has differed
        // from the debounced level for DEBOUNCE_LIMIT consecutive cycles.
        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            if (sync_out == level_q) begin
                // Any return to the current level restarts the count.
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d  = sync_out;
                db_cnt_d = '0;
                // Pulses are registered alongside the level so they line up
                // with the first cycle the new level is visible.
                rise_d   = sync_out;
                fall_d   = ~sync_out;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Debounced level, counter and edge-pulse registers.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                db_cnt_q <= '0;
                level_q  <= RESET_STATE;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
            end
        end

        // Long-press counter: runs while the debounced level is 1, saturates at
        // LONG_LIMIT so the pulse fires once per press.
        always_comb begin
            long_cnt_d = long_cnt_q;
            long_d     = 1'b0;
            if (!level_q) begin
                long_cnt_d = '0;
            end else if (long_cnt_q != LONG_MAX) begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
                long_d     = (long_cnt_q == LONG_LAST);
            end
        end

        // Long-press counter and pulse registers.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                long_cnt_q <= '0;
                long_q     <= 1'b0;
            end else begin
                long_cnt_q <= long_cnt_d;
                long_q     <= long_d;
            end
        end

        assign o_Switch[n] = level_q;
        assign o_Rise[n]   = rise_q;
        assign o_Fall[n]   = fall_q;
        assign o_Long[n]   = long_q;

    end : g_ch

endmodule

// File: tb/tb_debounce_switch_array.sv
// Self-checking bench for debounce_switch_array: directed scenarios plus random
// toggling, all compared against a sample-window reference model.

module tb_debounce_switch_array;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DB     = 4;
    localparam int unsigned SS     = 2;
    localparam int unsigned LL     = 10;
    localparam logic        RS     = 1'b0;

    logic              i_Clk = 1'b0;
    logic              i_Rst = 1'b0;
    logic [NUM_CH-1:0] i_Switch = '0;
    logic [NUM_CH-1:0] o_Switch, o_Rise, o_Fall, o_Long;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: raw samples, newest first; a level is accepted when the
    // samples seen by the counter (delayed by SS) are all different for DB edges.
    logic [NUM_CH-1:0] hist[$];
    logic [NUM_CH-1:0] m_level, m_rise, m_fall, m_long;
    int                m_run[NUM_CH];
    int                rise_cnt[NUM_CH];
    int                fall_cnt[NUM_CH];
    int                long_cnt[NUM_CH];

    always #5 i_Clk = ~i_Clk;

    debounce_switch_array #(
        .NUM_CH         (NUM_CH),
        .DEBOUNCE_LIMIT (DB),
        .SYNC_STAGES    (SS),
        .LONG_LIMIT     (LL),
        .RESET_STATE    (RS)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Rise   (o_Rise),
        .o_Fall   (o_Fall),
        .o_Long   (o_Long)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < int'(SS + DB); k++) hist.push_back({NUM_CH{RS}});
        m_level = {NUM_CH{RS}};
        m_rise  = '0;
        m_fall  = '0;
        m_long  = '0;
        for (int c = 0; c < int'(NUM_CH); c++) m_run[c] = 0;
    endfunction

    // Predict the outputs after the coming edge from the current raw inputs.
    function automatic void model_step();
        logic flip;
        hist.push_front(i_Switch);
        if (hist.size() > int'(SS + DB)) void'(hist.pop_back());
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (m_level[c]) m_run[c]++;
            else m_run[c] = 0;
            m_long[c] = m_level[c] && (m_run[c] == int'(LL));
            flip = 1'b1;
            for (int k = int'(SS); k < int'(SS + DB); k++)
                if (hist[k][c] == m_level[c]) flip = 1'b0;
            m_rise[c] = flip && !m_level[c];
            m_fall[c] = flip && m_level[c];
            if (flip) m_level[c] = ~m_level[c];
        end
    endfunction

    // One clock: step the model, let the edge pass, compare all outputs.
    task automatic tick();
        model_step();
        @(posedge i_Clk);
        #1;
        check("o_Switch", 32'(o_Switch), 32'(m_level));
        check("o_Rise",   32'(o_Rise),   32'(m_rise));
        check("o_Fall",   32'(o_Fall),   32'(m_fall));
        check("o_Long",   32'(o_Long),   32'(m_long));
        for (int c = 0; c < int'(NUM_CH); c++) begin
            rise_cnt[c] += int'(o_Rise[c]);
            fall_cnt[c] += int'(o_Fall[c]);
            long_cnt[c] += int'(o_Long[c]);
        end
    endtask

    function automatic void clear_counts();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            long_cnt[c] = 0;
        end
    endfunction

    // Tick until the selected output bit (0: o_Switch, 1: o_Long) reads v;
    // n = edges taken, or max+1 if the bound expired.
    task automatic wait_bit(input int sel, input int c, input logic v, input int max,
                            output int n);
        logic cur;
        n = 0;
        do begin
            tick();
            n++;
            cur = (sel == 0) ? o_Switch[c] : o_Long[c];
        end while (cur !== v && n <= max);
    endtask

    // Asynchronous reset asserted mid-cycle, held for 'hold' edges.
    task automatic apply_reset(input int hold);
        #2 i_Rst = 1'b1;
        #1;
        check("rst_async_sw",   32'(o_Switch), 32'({NUM_CH{RS}}));
        check("rst_async_rise", 32'(o_Rise),   32'd0);
        check("rst_async_fall", 32'(o_Fall),   32'd0);
        check("rst_async_long", 32'(o_Long),   32'd0);
        model_reset();
        repeat (hold) begin
            @(posedge i_Clk);
            #1;
            check("rst_hold_sw",    32'(o_Switch), 32'({NUM_CH{RS}}));
            check("rst_hold_pulse", 32'(o_Rise | o_Fall | o_Long), 32'd0);
        end
        i_Rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hold_left[NUM_CH];

        // 1. Reset with both inputs high.
        i_Switch = 2'b11;
        repeat (2) @(posedge i_Clk);
        #1;
        apply_reset(3);
        i_Switch = 2'b00;
        repeat (3) tick();

        // 2. Clean press on ch0, then release.
        clear_counts();
        i_Switch = 2'b01;
        wait_bit(0, 0, 1'b1, 20, n);
        check("press_latency", 32'(n), 32'd6);
        check("press_rise", 32'(o_Rise), 32'b01);
        check("press_ch1_idle", 32'(o_Switch[1]), 32'd0);
        i_Switch = 2'b00;
        wait_bit(0, 0, 1'b0, 20, n);
        check("release_latency", 32'(n), 32'd6);
        check("release_fall", 32'(o_Fall), 32'b01);

        // 3. Bounce on ch0: 1,1,1,0 then 1 held.
        clear_counts();
        i_Switch = 2'b01;
        repeat (3) tick();
        i_Switch = 2'b00;
        tick();
        i_Switch = 2'b01;
        wait_bit(0, 0, 1'b1, 20, n);
        check("bounce_latency", 32'(n), 32'd6);
        repeat (3) tick();
        check("bounce_one_rise", 32'(rise_cnt[0]), 32'd1);
        i_Switch = 2'b00;
        wait_bit(0, 0, 1'b0, 20, n);

        // 4. Sub-limit glitch on ch1.
        clear_counts();
        i_Switch = 2'b10;
        repeat (3) tick();
        i_Switch = 2'b00;
        repeat (10) tick();
        check("glitch_level", 32'(o_Switch[1]), 32'd0);
        check("glitch_edges", 32'(rise_cnt[1] + fall_cnt[1]), 32'd0);

        // 5. Long press, release, press again.
        clear_counts();
        i_Switch = 2'b01;
        wait_bit(0, 0, 1'b1, 20, n);
        wait_bit(1, 0, 1'b1, 30, n);
        check("long_delay", 32'(n), 32'd10);
        long_cnt[0] = 0;
        repeat (25) tick();
        check("long_no_repeat", 32'(long_cnt[0]), 32'd0);
        i_Switch = 2'b00;
        wait_bit(0, 0, 1'b0, 20, n);
        check("long_release_fall", 32'(o_Fall[0]), 32'd1);
        i_Switch = 2'b01;
        wait_bit(0, 0, 1'b1, 20, n);
        wait_bit(1, 0, 1'b1, 30, n);
        check("long_again_delay", 32'(n), 32'd10);
        i_Switch = 2'b00;
        wait_bit(0, 0, 1'b0, 20, n);

        // 6a. Simultaneous change on both channels.
        i_Switch = 2'b11;
        wait_bit(0, 0, 1'b1, 20, n);
        check("simul_rise_level", 32'(o_Switch), 32'b11);
        check("simul_rise_pulse", 32'(o_Rise), 32'b11);
        i_Switch = 2'b00;
        wait_bit(0, 0, 1'b0, 20, n);
        check("simul_fall_level", 32'(o_Switch), 32'b00);
        check("simul_fall_pulse", 32'(o_Fall), 32'b11);

        // 6b. Reset after two stable counting cycles discards the count.
        i_Switch = 2'b01;
        repeat (int'(SS) + 2) tick();
        apply_reset(2);
        wait_bit(0, 0, 1'b1, 20, n);
        check("rst_restart_latency", 32'(n), 32'd6);
        i_Switch = 2'b00;
        wait_bit(0, 0, 1'b0, 20, n);

        // Random hold lengths per channel, with one reset mid-stream.
        for (int c = 0; c < int'(NUM_CH); c++) hold_left[c] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (hold_left[c] == 0) begin
                    i_Switch[c]  = $urandom_range(0, 1) == 1;
                    hold_left[c] = $urandom_range(1, 20);
                end else begin
                    hold_left[c]--;
                end
            end
            if (cyc == 300) apply_reset(1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debounce_switch_array.md
Name: debounce_switch_array

Overview:
Parametrised N-channel debouncer for GoBoard push-buttons and switches.
- Each channel has a metastability synchroniser, a stability counter, a debounced level output, one-cycle rise/fall pulses and a one-shot long-press pulse.
- Sits directly behind the FPGA switch pins, feeding LED/7-segment/UART logic.
- Replaces per-button single-channel debouncers with one instance.

Parameters:
NUM_CH, 4, number of independent channels
DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a new level (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
LONG_LIMIT, 25000000, cycles a debounced 1 must persist before o_Long pulses (>=1)
RESET_STATE, 1'b0, debounced level loaded into every channel at reset

Ports:
i_Clk  input  1  system clock (25 MHz on GoBoard)
i_Rst  input  1  asynchronous, active-high reset
i_Switch  input  NUM_CH  raw asynchronous switch inputs, bit n = channel n
o_Switch  output  NUM_CH  debounced levels
o_Rise  output  NUM_CH  one-cycle pulse when debounced level goes 0->1
o_Fall  output  NUM_CH  one-cycle pulse when debounced level goes 1->0
o_Long  output  NUM_CH  one-cycle pulse when level has been 1 for LONG_LIMIT cycles

Behaviour:
- Single clock i_Clk; i_Rst asynchronous, active-high; all flops clear on posedge i_Rst and stay cleared while i_Rst is high.
- Reset values:
  - synchroniser flops = RESET_STATE
  - o_Switch = RESET_STATE (all bits)
  - counters = 0
  - o_Rise = o_Fall = o_Long = 0
- Channels are fully independent. No shared state; a simultaneous event on any set of channels is handled per channel with no interaction.
- Synchroniser: SYNC_STAGES-deep flop chain per bit. s_n is the last stage.
- Stability counter, width clog2(DEBOUNCE_LIMIT+1), derived internally:
  - if s_n == o_Switch[n]: counter <= 0
  - else if counter == DEBOUNCE_LIMIT-1: o_Switch[n] <= s_n, counter <= 0
  - else: counter <= counter+1
- Latency:
  - a clean raw change is reflected on o_Switch exactly SYNC_STAGES + DEBOUNCE_LIMIT rising edges after the first edge that samples the new raw value
  - any return of s_n to the current level before that point restarts the count from 0
- Counter never exceeds DEBOUNCE_LIMIT-1, so there is no wrap-around.
- Edge pulses:
  - o_Rise[n] is registered; high for exactly the one cycle in which o_Switch[n] first reads 1
  - o_Fall[n] likewise for the first cycle in which o_Switch[n] reads 0
  - never both high; never high on consecutive cycles for the same channel (minimum interval is DEBOUNCE_LIMIT cycles)
- Long-press counter, per channel, width clog2(LONG_LIMIT+1):
  - clears to 0 in any cycle o_Switch[n] == 0
  - increments while o_Switch[n] == 1, saturating at LONG_LIMIT
  - o_Long[n] pulses for one cycle on the cycle the counter transitions LONG_LIMIT-1 -> LONG_LIMIT, i.e. the LONG_LIMIT-th cycle after o_Rise
  - no repeat until the level falls and rises again
- RESET_STATE = 1:
  - no o_Rise pulse out of reset
  - the long-press counter starts from 0 at reset release, so o_Long fires LONG_LIMIT cycles after reset if the input is held high
- Reset mid-operation: pending counts are discarded and outputs return to reset values immediately (asynchronously). No edge pulse is generated by reset itself.
- All outputs are registered. No combinational path from i_Switch to any output.

Test Plan:
Common configuration: NUM_CH=2, DEBOUNCE_LIMIT=4, SYNC_STAGES=2, LONG_LIMIT=10, RESET_STATE=0.
1. Reset: assert i_Rst mid-cycle with i_Switch=2'b11 -> all outputs 0 asynchronously; they remain 0 while i_Rst is high.
2. Clean press: i_Switch[0] 0->1 and held -> o_Switch[0]=1 on the 6th edge after the first sampling edge; o_Rise[0]=1 for exactly that cycle; channel 1 unaffected.
3. Bounce: on ch0, drive 1 for 3 cycles, then 0 for 1 cycle, then 1 held -> no output change during the glitch; o_Switch[0] rises 6 edges after the final 0->1; exactly one o_Rise pulse.
4. Sub-limit glitch: a 3-cycle 1 pulse on i_Switch[1] -> o_Switch[1] stays 0; o_Rise[1] and o_Fall[1] never assert.
5. Long press: hold ch0 high -> o_Long[0] pulses once, 10 cycles after o_Rise[0], then stays 0. Release -> o_Fall[0] pulses. Press again -> o_Long[0] fires again.
6. Simultaneous and reset-mid-count: both channels change on the same edge -> both outputs update on the same cycle with coincident pulses. A separate run asserts i_Rst after 2 stable cycles -> no update; the count restarts after reset release.
